// File: rtl/data_window_buffer.sv
// Multi-channel sliding-window sample buffer: keeps the last DEPTH samples per lane and,
// on request, freezes and streams the window oldest-first over a valid/ready port.
//
// state | meaning
// FILL  | accepting samples, fewer than DEPTH held
// RUN   | accepting samples, window full, each write overwrites the oldest
// DRAIN | window frozen, streaming out oldest-first, input stalled
module data_window_buffer #(
  parameter int WORDWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int CHANNELS  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHANNELS*WORDWIDTH-1:0]   in_data,
  input  logic                            drain_req,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHANNELS*WORDWIDTH-1:0]   out_data,
  output logic                            out_last,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            full,
  output logic                            busy
);

  localparam int W  = CHANNELS * WORDWIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_new, start_ptr, rd_next;
  logic [CW-1:0] remaining, count_new;
  logic [CW:0]   start_sum;
  logic          wr_en, drain_go, hs;

  always_comb begin
    wr_en      = in_valid && in_ready;
    wr_ptr_new = wr_ptr;
    count_new  = count;
    if (wr_en) begin
      wr_ptr_new = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (count != CNT_MAX) count_new = count + 1'b1;
    end
    // Oldest sample sits count_new slots behind the post-write pointer, modulo DEPTH.
    start_sum = (CW + 1)'(wr_ptr_new) + DEPTH_X - {1'b0, count_new};
    if (start_sum >= DEPTH_X) start_sum = start_sum - DEPTH_X;
    start_ptr = start_sum[PW-1:0];
    rd_next   = (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
    drain_go  = (state != DRAIN) && drain_req && (count_new != '0);
    hs        = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        FILL, RUN: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr_new;
            count  <= count_new;
            full   <= (count_new == CNT_MAX);
            if (count_new == CNT_MAX) state <= RUN;
          end
          if (drain_go) begin
            state     <= DRAIN;
            rd_ptr    <= start_ptr;
            remaining <= count_new;
            // The same-cycle write is not yet in mem, so forward it when it is the oldest.
            out_data  <= (wr_en && start_ptr == wr_ptr) ? in_data : mem[start_ptr];
            out_valid <= 1'b1;
            out_last  <= (count_new == CW'(1));
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (hs) begin
            if (remaining > CW'(1)) begin
              rd_ptr    <= rd_next;
              out_data  <= mem[rd_next];
              remaining <= remaining - 1'b1;
              out_last  <= (remaining == CW'(2));
            end else begin
              state     <= FILL;
              count     <= '0;
              wr_ptr    <= '0;
              full      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_data_window_buffer.sv
// Bench for data_window_buffer: a single-lane D=16 instance and a 3-lane D=5 instance,
// driven by directed steps with a window model feeding an expected-output queue.
module tb_data_window_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0, drain_req = 1'b0, out_ready = 1'b0;
  logic [23:0] in_data = '0;

  logic       a_in_ready, a_out_valid, a_out_last, a_full, a_busy;
  logic [7:0] a_out_data;
  logic [4:0] a_count;
  logic        b_in_ready, b_out_valid, b_out_last, b_full, b_busy;
  logic [23:0] b_out_data;
  logic [2:0]  b_count;

  int checks = 0;
  int failures = 0;
  logic [23:0] win[$];
  logic [23:0] expq[$];
  int dep = 16;

  always #5 clk = ~clk;

  data_window_buffer #(.WORDWIDTH(8), .DEPTH(16), .CHANNELS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .in_data(in_data[7:0]), .drain_req(drain_req && !sel), .out_valid(a_out_valid),
    .out_ready(out_ready && !sel), .out_data(a_out_data), .out_last(a_out_last),
    .count(a_count), .full(a_full), .busy(a_busy));

  data_window_buffer #(.WORDWIDTH(8), .DEPTH(5), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .in_data(in_data), .drain_req(drain_req && sel), .out_valid(b_out_valid),
    .out_ready(out_ready && sel), .out_data(b_out_data), .out_last(b_out_last),
    .count(b_count), .full(b_full), .busy(b_busy));

  wire        o_in_ready  = sel ? b_in_ready  : a_in_ready;
  wire        o_out_valid = sel ? b_out_valid : a_out_valid;
  wire        o_out_last  = sel ? b_out_last  : a_out_last;
  wire        o_full      = sel ? b_full      : a_full;
  wire        o_busy      = sel ? b_busy      : a_busy;
  wire [23:0] o_out_data  = sel ? b_out_data  : {16'h0, a_out_data};
  wire [4:0]  o_count     = sel ? {2'b0, b_count} : a_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take_window();
    if (win.size() > 0) begin
      expq = win;
      win.delete();
    end
  endtask

  task automatic wr(input logic [23:0] v, input logic req);
    chk("in_ready_before_write", 32'(o_in_ready), 32'd1);
    in_valid = 1'b1; in_data = v; drain_req = req;
    @(posedge clk); #1;
    in_valid = 1'b0; drain_req = 1'b0;
    win.push_back(v);
    if (win.size() > dep) void'(win.pop_front());
    if (req) take_window();
    else chk("count_after_write", 32'(o_count), 32'(win.size()));
  endtask

  task automatic req_only();
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    take_window();
  endtask

  // pat 0: out_ready always high; pat 1: out_ready 1,0,0 repeating.
  task automatic drain(input int pat, input logic inv);
    int budget = 0;
    int k = 0;
    logic r;
    chk("busy_in_drain", 32'(o_busy), 32'd1);
    chk("in_ready_in_drain", 32'(o_in_ready), 32'd0);
    while (expq.size() > 0 && budget < 200) begin
      chk("out_valid", 32'(o_out_valid), 32'd1);
      chk("out_data", 32'(o_out_data), 32'(expq[0]));
      chk("out_last", 32'(o_out_last), 32'(expq.size() == 1));
      r = (pat == 0) ? 1'b1 : (k % 3 == 0);
      k++;
      out_ready = r;
      in_valid = inv && (expq.size() > 1);
      in_data = 24'hEE;
      @(posedge clk); #1;
      if (r) void'(expq.pop_front());
      budget++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk("drain_words_left", 32'(expq.size()), 32'd0);
    chk("out_valid_after", 32'(o_out_valid), 32'd0);
    chk("busy_after", 32'(o_busy), 32'd0);
    chk("in_ready_after", 32'(o_in_ready), 32'd1);
    chk("count_after", 32'(o_count), 32'd0);
    chk("full_after", 32'(o_full), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_count", 32'(o_count), 32'd0);
    chk("reset_out_data", 32'(o_out_data), 32'd0);

    // Reset mid-stream
    wr(24'h31, 1'b0); wr(24'h32, 1'b0); wr(24'h33, 1'b0);
    in_valid = 1'b1; in_data = 24'h34;
    #2 rst = 1'b0;
    #2 in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    win.delete();
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_last", 32'(o_out_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // Partial fill
    for (int i = 1; i <= 5; i++) wr(24'(i), 1'b0);
    chk("partial_full", 32'(o_full), 32'd0);
    req_only();
    drain(0, 1'b0);

    // Wrap: 20 writes into a 16-deep window
    for (int i = 0; i < 20; i++) wr(24'(i), 1'b0);
    chk("wrap_full", 32'(o_full), 32'd1);
    chk("wrap_count", 32'(o_count), 32'd16);
    req_only();
    drain(0, 1'b0);

    // Backpressure
    for (int i = 0; i < 18; i++) wr(24'(8'h80 + i), 1'b0);
    req_only();
    drain(1, 1'b0);

    // Simultaneous write + drain_req; input offered during drain must be ignored
    wr(24'h11, 1'b0); wr(24'h22, 1'b0); wr(24'h33, 1'b0);
    wr(24'hAA, 1'b1);
    drain(1, 1'b1);

    // Single sample forwarded straight into the window
    wr(24'h77, 1'b1);
    drain(0, 1'b0);

    // Three lanes, DEPTH=5
    sel = 1'b1; dep = 5;
    chk("b_idle_count", 32'(o_count), 32'd0);
    for (int i = 0; i < 7; i++) wr({8'(8'hC0 + i), 8'(8'h50 + 3 * i), 8'(i + 1)}, 1'b0);
    chk("b_full", 32'(o_full), 32'd1);
    req_only();
    drain(1, 1'b0);

    // drain_req with nothing held
    req_only();
    for (int i = 0; i < 3; i++) begin
      chk("empty_req_out_valid", 32'(o_out_valid), 32'd0);
      chk("empty_req_busy", 32'(o_busy), 32'd0);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
